// File: rtl/hazard_unit_sb.sv
// Hazard unit for the in-order RV32 pipeline.
// Covers N-stage operand forwarding, load-use stalls, a register scoreboard
// for the multi-cycle MUL/DIV unit, a stretched redirect flush and a
// saturating stall-cycle counter.
module hazard_unit_sb #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int FWD_STAGES   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [FWD_STAGES-1:0]       FWD_rd_reg_write,
    input  logic [FWD_STAGES*REG_W-1:0] FWD_rd,
    input  logic [REG_W-1:0]            EXEC_rs1,
    input  logic [REG_W-1:0]            EXEC_rs2,
    output logic [FWD_STAGES-1:0]       FWD_rs1,
    output logic [FWD_STAGES-1:0]       FWD_rs2,
    input  logic [REG_W-1:0]            FETCH_rs1,
    input  logic [REG_W-1:0]            FETCH_rs2,
    input  logic [REG_W-1:0]            FETCH_rd,
    input  logic                        FETCH_mc,
    input  logic                        FETCH_valid,
    input  logic                        MEM_valid,
    input  logic                        EXEC_mem2reg,
    input  logic [REG_W-1:0]            EXEC_rd,
    input  logic                        BRA,
    input  logic                        JMP,
    input  logic                        MC_issue,
    input  logic [REG_W-1:0]            MC_issue_rd,
    input  logic                        MC_done,
    input  logic [REG_W-1:0]            MC_done_rd,
    input  logic                        MC_busy,
    output logic                        FETCH_stall,
    output logic                        EXEC_stall,
    output logic                        EXEC_flush,
    output logic                        MEM_flush,
    output logic [NUM_REGS-1:0]         sb_busy,
    output logic                        sb_err,
    output logic [CNT_W-1:0]            stall_cnt
);

    // Four bits cover the full 1..15 range of FLUSH_CYCLES.
    localparam int FC_W = 4;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    logic [FC_W-1:0]     flush_cnt;
    logic [NUM_REGS-1:0] sb_next;
    logic                load_stall;
    logic                sb_stall;
    logic                redirect;

    // Forwarding select: nearest writing stage wins, x0 is never forwarded.
    always_comb begin
        logic hit1, hit2;
        FWD_rs1 = '0;
        FWD_rs2 = '0;
        hit1    = 1'b0;
        hit2    = 1'b0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (!hit1 && FWD_rd_reg_write[i] && EXEC_rs1 != '0 &&
                FWD_rd[i*REG_W +: REG_W] == EXEC_rs1) begin
                FWD_rs1[i] = 1'b1;
                hit1       = 1'b1;
            end
            if (!hit2 && FWD_rd_reg_write[i] && EXEC_rs2 != '0 &&
                FWD_rd[i*REG_W +: REG_W] == EXEC_rs2) begin
                FWD_rs2[i] = 1'b1;
                hit2       = 1'b1;
            end
        end
    end

    // Scoreboard next state: completion clears, issue sets (set wins), x0 stays clear.
    always_comb begin
        sb_next = sb_busy;
        if (MC_done)
            sb_next[MC_done_rd] = 1'b0;
        if (MC_issue && MC_issue_rd != '0)
            sb_next[MC_issue_rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    // Stall sources; scoreboard hazards look at next state so a same-cycle
    // completion releases the decoding instruction immediately.
    always_comb begin
        load_stall  = EXEC_mem2reg && EXEC_rd != '0 &&
                      (FETCH_rs1 == EXEC_rd || FETCH_rs2 == EXEC_rd);
        sb_stall    = (FETCH_rs1 != '0 && sb_next[FETCH_rs1]) ||
                      (FETCH_rs2 != '0 && sb_next[FETCH_rs2]) ||
                      (FETCH_rd  != '0 && sb_next[FETCH_rd])  ||
                      (FETCH_mc && MC_busy);
        redirect    = BRA | JMP;
        EXEC_stall  = ~MEM_valid;
        MEM_flush   = EXEC_stall;
        FETCH_stall = ~FETCH_valid | EXEC_stall | load_stall | sb_stall;
        EXEC_flush  = redirect | (flush_cnt != '0) | FETCH_stall;
    end

    // Scoreboard register and sticky completion-without-issue error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_busy <= '0;
            sb_err  <= 1'b0;
        end else begin
            sb_busy <= sb_next;
            if (MC_done && !sb_busy[MC_done_rd])
                sb_err <= 1'b1;
        end
    end

    // Redirect flush stretcher: reload on every redirect, otherwise count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flush_cnt <= '0;
        else if (redirect)
            flush_cnt <= FLUSH_LOAD;
        else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (FETCH_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Parametrised next-generation hazard unit for the in-order RV32 pipeline. It extends operand forwarding to N producer stages, with nearest-stage priority and x0 suppression. It adds a register scoreboard for a multi-cycle execution unit (MUL/DIV) with RAW, WAW and structural stalls. It also adds a redirect flush that is stretched over a configurable number of cycles for deeper front-ends, and a saturating stall-cycle performance counter.

Parameters:
NUM_REGS, 32, architectural register count (power of two)
REG_W, 5, register index width, equal to log2(NUM_REGS)
FWD_STAGES, 2, number of forwarding sources; index 0 = nearest (MEM), index 1 = WB, and so on
FLUSH_CYCLES, 1, cycles EXEC_flush stays asserted after a BRA/JMP redirect (1..15)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
FWD_rd_reg_write  in  FWD_STAGES  per-stage register-write enable
FWD_rd  in  FWD_STAGES*REG_W  per-stage destination; stage i occupies bits [i*REG_W +: REG_W]
EXEC_rs1, EXEC_rs2  in  REG_W  source registers of the instruction in EXEC
FWD_rs1, FWD_rs2  out  FWD_STAGES  one-hot forwarding select; all zero selects the register file
FETCH_rs1, FETCH_rs2, FETCH_rd  in  REG_W  registers of the decoding instruction
FETCH_mc  in  1  decoding instruction targets the multi-cycle unit
FETCH_valid, MEM_valid  in  1  I-fetch / D-fetch data valid
EXEC_mem2reg  in  1  instruction in EXEC is a load
EXEC_rd  in  REG_W  destination of the instruction in EXEC
BRA, JMP  in  1  taken-branch mispredict / jump resolved in EXEC
MC_issue  in  1  multi-cycle op leaves EXEC this cycle (already qualified by the caller)
MC_issue_rd  in  REG_W  destination of the issuing op
MC_done  in  1  multi-cycle result is written back this cycle
MC_done_rd  in  REG_W  destination of the completing op
MC_busy  in  1  multi-cycle unit cannot accept a new op
FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush  out  1  pipeline control
sb_busy  out  NUM_REGS  scoreboard pending bits
sb_err  out  1  sticky: MC_done arrived for a register that was not pending
stall_cnt  out  CNT_W  saturating count of FETCH_stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): sb_busy=0, sb_err=0, stall_cnt=0, flush counter=0. Combinational outputs then follow their inputs with an empty scoreboard.
- Forwarding (combinational):
  - FWD_rs1[i]=1 when stage i writes, FWD_rd(i)==EXEC_rs1, EXEC_rs1!=0, and no lower-index stage matches.
  - FWD_rs2 follows the same rule using EXEC_rs2.
  - At most one bit of each output is set.
- load_stall = EXEC_mem2reg && EXEC_rd!=0 && (FETCH_rs1==EXEC_rd || FETCH_rs2==EXEC_rd).
- sb_stall (all combinational):
  - RAW: sb_busy[FETCH_rs1] or sb_busy[FETCH_rs2] is set for a nonzero index.
  - WAW: sb_busy[FETCH_rd] is set for FETCH_rd!=0.
  - Structural: FETCH_mc && MC_busy.
- A register completing this cycle (MC_done with a matching MC_done_rd) does not cause a stall; the bypass is taken from sb_busy next-state.
- EXEC_stall = ~MEM_valid.
- MEM_flush = EXEC_stall.
- FETCH_stall = ~FETCH_valid | EXEC_stall | load_stall | sb_stall.
- Flush counter:
  - BRA|JMP loads the counter with FLUSH_CYCLES-1.
  - While the counter is nonzero it decrements each cycle.
  - A new redirect while counting reloads the counter.
  - EXEC_flush = BRA | JMP | (counter!=0) | FETCH_stall.
- Scoreboard update each cycle:
  - MC_done clears bit MC_done_rd.
  - MC_issue sets bit MC_issue_rd; issue to x0 sets nothing.
  - Same register issued and completed in the same cycle: the set wins.
  - Bit 0 is never set.
- sb_err sets when MC_done arrives and sb_busy[MC_done_rd]==0; it clears only on reset.
- stall_cnt increments on every cycle with FETCH_stall=1 and saturates at all-ones. No wrap-around.
- Latency: forwarding and stalls are combinational (0 cycles). Scoreboard and counters update at the next clock edge.

Test Plan:
1. Forward priority: stage0 and stage1 both write x5, EXEC_rs1=5 -> FWD_rs1=01. With only stage1 writing -> 10. With EXEC_rs1=0 and both stages writing x0 -> 00.
2. Load-use: EXEC_mem2reg=1, EXEC_rd=7, FETCH_rs2=7 -> FETCH_stall=1, EXEC_flush=1, and stall_cnt goes 0->1 next cycle. With EXEC_rd=0 -> no stall.
3. Scoreboard RAW/WAW:
   - MC_issue rd=12 -> next cycle sb_busy[12]=1.
   - FETCH_rs1=12 -> stall; FETCH_rd=12 -> stall.
   - MC_done rd=12 -> stall drops in the same cycle, and sb_busy[12]=0 after the edge.
4. Simultaneous issue/done on rd=9 with sb_busy[9]=1 -> sb_busy[9] stays 1, sb_err stays 0. Spurious MC_done rd=3 -> sb_err=1 and stays 1.
5. FLUSH_CYCLES=3: BRA pulse for 1 cycle -> EXEC_flush high for 3 cycles. A second JMP in cycle 2 -> high through cycle 4.
6. Assert rst_n=0 mid-operation with sb_busy nonzero and stall_cnt=2^CNT_W-1 -> all state 0 immediately, without waiting for a clock edge. Separately, preload a saturated counter and hold FETCH_stall -> stall_cnt holds at all-ones.
